// File: rtl/iopin_arbiter.sv
// Round-robin arbiter sharing one bidirectional ioblock pad among NREQ requesters.
// Drives the ioblock TS/OUT inputs from the current owner and samples its IN output.
// Every release is followed by TURN tristated cycles and one idle arbitration cycle,
// so two owners never drive the pad back-to-back.
module iopin_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned MAXHOLD = 16,
    parameter int unsigned TURN    = 1
) (
    input  logic            IOCLK,
    input  logic            RST_N,
    input  logic [NREQ-1:0] REQ,
    input  logic [NREQ-1:0] WR,
    input  logic [NREQ-1:0] DOUT,
    output logic [NREQ-1:0] GNT,
    output logic            TS,
    output logic            OUT,
    input  logic            IN,
    output logic            RDATA,
    output logic [NREQ-1:0] RVLD
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned HW = $clog2(MAXHOLD);
    localparam int unsigned TW = 3;

    localparam logic [HW-1:0]   HoldMax  = HW'(MAXHOLD - 1);
    localparam logic [TW-1:0]   TurnLast = TW'((TURN > 0) ? TURN - 1 : 0);
    localparam logic [NREQ-1:0] One      = NREQ'(1);
    localparam logic [IW-1:0]   LastInit = IW'(NREQ - 1);

    typedef enum logic [1:0] {StIdle, StGrant, StTurn} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   own_q;
    logic [IW-1:0]   last_q;
    logic [HW-1:0]   hold_q;
    logic [TW-1:0]   turn_q;
    logic [NREQ-1:0] gnt_q;
    logic            rdata_q;
    logic [NREQ-1:0] rvld_q;

    logic            any_req;
    logic [IW-1:0]   pick;
    logic [NREQ-1:0] own_oh;
    logic            own_req;
    logic            other_req;
    logic            release_own;
    logic            listen;

    // First requester after last_q in circular order.
    function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] req,
                                              input logic [IW-1:0]   last);
        logic [IW-1:0] sel;
        logic [IW-1:0] idx;
        logic          hit;
        sel = '0;
        hit = 1'b0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            idx = IW'((32'(last) + i) % NREQ);
            if (!hit && req[idx]) begin
                hit = 1'b1;
                sel = idx;
            end
        end
        return sel;
    endfunction

    // Arbitration and release conditions derived from the registered owner.
    always_comb begin
        any_req     = |REQ;
        pick        = rr_pick(REQ, last_q);
        own_oh      = One << own_q;
        own_req     = REQ[own_q];
        other_req   = |(REQ & ~own_oh);
        release_own = !own_req || ((hold_q == HoldMax) && other_req);
        listen      = (state_q == StGrant) && own_req && !WR[own_q];
    end

    // State register.
    always_ff @(posedge IOCLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (any_req) state_d = StGrant;
            end
            StGrant: begin
                if (release_own) state_d = (TURN > 0) ? StTurn : StIdle;
            end
            StTurn: begin
                if (turn_q == TurnLast) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Ownership, hold and turnaround bookkeeping.
    always_ff @(posedge IOCLK or negedge RST_N) begin
        if (!RST_N) begin
            gnt_q  <= '0;
            own_q  <= '0;
            last_q <= LastInit;
            hold_q <= '0;
            turn_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (any_req) begin
                        gnt_q  <= One << pick;
                        own_q  <= pick;
                        last_q <= pick;
                        hold_q <= '0;
                    end
                end
                StGrant: begin
                    if (release_own) begin
                        gnt_q  <= '0;
                        turn_q <= '0;
                    end else if (hold_q != HoldMax) begin
                        hold_q <= hold_q + HW'(1);
                    end
                end
                StTurn: begin
                    turn_q <= turn_q + TW'(1);
                end
                default: begin
                    gnt_q <= '0;
                end
            endcase
        end
    end

    // Pad sample for a listening owner; RDATA holds between samples.
    always_ff @(posedge IOCLK or negedge RST_N) begin
        if (!RST_N) begin
            rdata_q <= 1'b0;
            rvld_q  <= '0;
        end else begin
            if (listen) begin
                rdata_q <= IN;
                rvld_q  <= own_oh;
            end else begin
                rvld_q  <= '0;
            end
        end
    end

    // Outputs; the pad is driven only while granted and the owner asks to write.
    always_comb begin
        TS    = (state_q == StGrant) && own_req && WR[own_q];
        OUT   = TS && DOUT[own_q];
        GNT   = gnt_q;
        RDATA = rdata_q;
        RVLD  = rvld_q;
    end

endmodule

// File: tb/tb_iopin_arbiter.sv
// Directed bench for iopin_arbiter: a default build (TURN=1) and a TURN=0 build
// share stimulus; a simple pad model resolves PIN from TS/OUT or an external driver.
module tb_iopin_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] wr;
    logic [3:0] dout;
    logic       pin_ext;
    logic       pin;

    logic [3:0] gnt;
    logic       ts;
    logic       out;
    logic       rdata;
    logic [3:0] rvld;

    logic [3:0] gnt0;
    logic       ts0;
    logic       out0;
    logic       rdata0;
    logic [3:0] rvld0;

    int n_tests;
    int n_fail;

    assign pin = ts ? out : pin_ext;

    iopin_arbiter #(.NREQ(4), .MAXHOLD(16), .TURN(1)) dut (
        .IOCLK(clk), .RST_N(rst_n), .REQ(req), .WR(wr), .DOUT(dout),
        .GNT(gnt), .TS(ts), .OUT(out), .IN(pin), .RDATA(rdata), .RVLD(rvld)
    );

    iopin_arbiter #(.NREQ(4), .MAXHOLD(16), .TURN(0)) dut_t0 (
        .IOCLK(clk), .RST_N(rst_n), .REQ(req), .WR(wr), .DOUT(dout),
        .GNT(gnt0), .TS(ts0), .OUT(out0), .IN(pin_ext), .RDATA(rdata0), .RVLD(rvld0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        req     = '0;
        wr      = '0;
        dout    = '0;
        pin_ext = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [3:0] exp_g;
    logic [3:0] pat;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        req     = '0;
        wr      = '0;
        dout    = '0;
        pin_ext = 1'b0;
        #3;
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_ts", 32'(ts), 32'h0);
        check("rst_out", 32'(out), 32'h0);
        check("rst_rdata", 32'(rdata), 32'h0);
        check("rst_rvld", 32'(rvld), 32'h0);

        // Single writer: owner 0 drives a 1 onto the pad.
        do_reset();
        req  = 4'b0001;
        wr   = 4'b0001;
        dout = 4'b0001;
        tick();
        check("w_gnt", 32'(gnt), 32'h1);
        check("w_ts", 32'(ts), 32'h1);
        check("w_out", 32'(out), 32'h1);
        check("w_pin", 32'(pin), 32'h1);
        tick();
        check("w_rvld", 32'(rvld), 32'h0);

        // Two competitors: hold limit, turnaround gap and round-robin return.
        do_reset();
        req = 4'b0101;
        for (int c = 0; c <= 36; c++) begin
            tick();
            if (c < 16)      exp_g = 4'b0001;
            else if (c < 18) exp_g = 4'b0000;
            else if (c < 34) exp_g = 4'b0100;
            else if (c < 36) exp_g = 4'b0000;
            else             exp_g = 4'b0001;
            check($sformatf("rr_c%0d", c), 32'(gnt), 32'(exp_g));
        end

        // Listening owner 1 samples the externally driven pad.
        do_reset();
        req = 4'b0010;
        tick();
        check("rd_gnt", 32'(gnt), 32'h2);
        pat = 4'b0110;
        for (int k = 0; k < 4; k++) begin
            pin_ext = pat[k];
            tick();
            check($sformatf("rd_data%0d", k), 32'(rdata), 32'(pat[k]));
            check($sformatf("rd_vld%0d", k), 32'(rvld), 32'h2);
            check($sformatf("rd_ts%0d", k), 32'(ts), 32'h0);
        end
        req = 4'b0000;
        tick();
        check("rd_vld_end", 32'(rvld), 32'h0);
        check("rd_hold", 32'(rdata), 32'h0);

        // Lone owner keeps the grant past MAXHOLD; drop releases with TURN gap.
        do_reset();
        req = 4'b0100;
        wr  = 4'b0100;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (c % 8 == 7) check($sformatf("alone_c%0d", c), 32'(gnt), 32'h4);
        end
        check("alone_ts", 32'(ts), 32'h1);
        req = 4'b0000;
        #1;
        check("alone_ts_drop", 32'(ts), 32'h0);
        tick();
        check("alone_rel_gnt", 32'(gnt), 32'h0);
        check("alone_rel_ts", 32'(ts), 32'h0);
        tick();
        check("alone_turn_gnt", 32'(gnt), 32'h0);
        check("alone_turn_ts", 32'(ts), 32'h0);

        // Asynchronous reset in the middle of a driving grant.
        do_reset();
        req  = 4'b0001;
        wr   = 4'b0001;
        dout = 4'b0001;
        tick();
        tick();
        check("ar_ts_before", 32'(ts), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_ts", 32'(ts), 32'h0);
        check("ar_gnt", 32'(gnt), 32'h0);
        check("ar_rvld", 32'(rvld), 32'h0);
        check("ar_out", 32'(out), 32'h0);
        req = 4'b1000;
        wr  = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("ar_first", 32'(gnt), 32'h8);

        // TURN=0 build: exactly one idle cycle between owners.
        do_reset();
        req = 4'b0011;
        tick();
        check("t0_own0", 32'(gnt0), 32'h1);
        req = 4'b0010;
        tick();
        check("t0_gap", 32'(gnt0), 32'h0);
        tick();
        check("t0_own1", 32'(gnt0), 32'h2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
